median_feeder: RTL

MEDIAN_FEEDER -- requirements
Module: median_feeder

---
 rtl/median_feeder.sv | 115 +++++++++++
 1 files changed

// File: rtl/median_feeder.sv
// Collects a 3x3 window of pixels, streams it to an external median filter as a
// 9-cycle strobed burst, then captures the filter's result and hands it downstream.
module median_feeder #(
  parameter int W   = 8,
  parameter int TMO = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] IN_DATA,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [W-1:0] DI,
  output logic         DSI,
  input  logic [W-1:0] DO,
  input  logic         DSO,
  output logic [W-1:0] OUT_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         BUSY,
  output logic         TMO_ERR
);

  localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [TW-1:0] r_tcnt;
  logic [W-1:0]  r_buf [0:8];
  logic [W-1:0]  r_out_data;
  logic          r_tmo_err;

  logic w_load;
  logic w_send;
  logic w_accept;
  logic w_tmo_hit;

  assign w_load    = (r_state == S_LOAD);
  assign w_send    = (r_state == S_SEND);
  assign w_accept  = w_load && IN_VALID;
  assign w_tmo_hit = (r_tcnt == TW'(TMO - 1));

  // Window storage needs no reset: every slot is rewritten before it is sent.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_buf[r_cnt] <= IN_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_LOAD;
      r_cnt      <= 4'd0;
      r_tcnt     <= '0;
      r_out_data <= '0;
      r_tmo_err  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (IN_VALID) begin
            if (r_cnt == 4'd8) begin
              r_cnt   <= 4'd0;
              r_state <= S_SEND;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_SEND: begin
          if (r_cnt == 4'd8) begin
            r_cnt   <= 4'd0;
            r_tcnt  <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WAIT: begin
          // A result arriving on the last permitted cycle still wins over the timeout.
          if (DSO) begin
            r_out_data <= DO;
            r_tcnt     <= '0;
            r_state    <= S_OUT;
          end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
            r_tcnt    <= '0;
            r_state   <= S_LOAD;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_OUT: begin
          if (OUT_READY) begin
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Strobe and pixel are decoded from state so an asynchronous reset drops them at once.
  assign DSI       = w_send;
  assign DI        = w_send ? r_buf[r_cnt] : '0;
  assign IN_READY  = w_load;
  assign OUT_VALID = (r_state == S_OUT);
  assign OUT_DATA  = r_out_data;
  assign BUSY      = !(w_load && (r_cnt == 4'd0));
  assign TMO_ERR   = r_tmo_err;

endmodule
